// File: rtl/mips16_loader_pkg.sv
// Shared encodings for the boot-time instruction-memory loader.
package mips16_loader_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEN_HI  = 4'd1,
    LEN_LO  = 4'd2,
    DATA_HI = 4'd3,
    DATA_LO = 4'd4,
    CSUM_HI = 4'd5,
    CSUM_LO = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // States in which the loader is consuming stream bytes.
  function automatic logic is_receiving(input state_t s);
    case (s)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO: is_receiving = 1'b1;
      default:                                            is_receiving = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/loader_watchdog.sv
// Idle-cycle counter: expires after TIMEOUT consecutive enabled cycles without a kick.
module loader_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count idle cycles; saturate at TIMEOUT so expiry stays asserted until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || kick) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

  assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a checksummed big-endian byte stream into 16-bit words
// for instruction RAM and releases the core from reset once the image verifies.
module imem_loader
  import mips16_loader_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam int          CNT_W = ADDR_W + 1;
  localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

  state_t             state, state_n;
  logic [7:0]         hi, hi_n;
  logic [CNT_W-1:0]   len, len_n;
  logic [CNT_W-1:0]   word_cnt, word_cnt_n;
  logic [15:0]        csum, csum_n;
  logic               in_ready_n, wr_en_n, cpu_reset_n, done_n, error_n;
  logic [ADDR_W-1:0]  wr_addr_n;
  logic [15:0]        wr_data_n;
  logic [1:0]         err_code_n;

  logic               xfer;
  logic               expired;
  logic [15:0]        rx_word;
  logic [16:0]        rx_len;
  logic [CNT_W-1:0]   cnt_inc;

  assign xfer    = in_valid & in_ready;
  assign rx_word = {hi, in_byte};
  assign rx_len  = {1'b0, hi, in_byte};
  assign cnt_inc = word_cnt + CNT_W'(1);

  loader_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .enable  (is_receiving(state)),
    .kick    (xfer),
    .expired (expired)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hi        <= 8'h00;
      len       <= '0;
      word_cnt  <= '0;
      csum      <= 16'h0000;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 16'h0000;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_n;
      hi        <= hi_n;
      len       <= len_n;
      word_cnt  <= word_cnt_n;
      csum      <= csum_n;
      in_ready  <= in_ready_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
      cpu_reset <= cpu_reset_n;
      done      <= done_n;
      error     <= error_n;
      err_code  <= err_code_n;
    end
  end

  // Next-state and next-output logic; a timeout overrides any same-cycle transfer.
  always_comb begin
    state_n     = state;
    hi_n        = hi;
    len_n       = len;
    word_cnt_n  = word_cnt;
    csum_n      = csum;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    cpu_reset_n = cpu_reset;
    done_n      = done;
    error_n     = error;
    err_code_n  = err_code;

    if (is_receiving(state) && expired) begin
      state_n     = ERROR;
      error_n     = 1'b1;
      err_code_n  = ERR_TIMEOUT;
      cpu_reset_n = 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state_n     = LEN_HI;
            word_cnt_n  = '0;
            csum_n      = 16'h0000;
            cpu_reset_n = 1'b1;
            done_n      = 1'b0;
            error_n     = 1'b0;
            err_code_n  = ERR_NONE;
          end else begin
            state_n = state;
          end
        end
        LEN_HI: begin
          if (xfer) begin
            hi_n    = in_byte;
            state_n = LEN_LO;
          end else begin
            state_n = state;
          end
        end
        LEN_LO: begin
          if (xfer) begin
            if ((rx_len == 17'd0) || (rx_len > MAX_N)) begin
              state_n    = ERROR;
              error_n    = 1'b1;
              err_code_n = ERR_LEN;
            end else begin
              len_n   = rx_len[CNT_W-1:0];
              state_n = DATA_HI;
            end
          end else begin
            state_n = state;
          end
        end
        DATA_HI: begin
          if (xfer) begin
            hi_n    = in_byte;
            state_n = DATA_LO;
          end else begin
            state_n = state;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            wr_en_n    = 1'b1;
            wr_data_n  = rx_word;
            wr_addr_n  = word_cnt[ADDR_W-1:0];
            csum_n     = csum + rx_word;
            word_cnt_n = cnt_inc;
            state_n    = (cnt_inc == len) ? CSUM_HI : DATA_HI;
          end else begin
            state_n = state;
          end
        end
        CSUM_HI: begin
          if (xfer) begin
            hi_n    = in_byte;
            state_n = CSUM_LO;
          end else begin
            state_n = state;
          end
        end
        CSUM_LO: begin
          if (xfer) begin
            if (rx_word == csum) begin
              state_n     = DONE;
              done_n      = 1'b1;
              cpu_reset_n = 1'b0;
            end else begin
              state_n    = ERROR;
              error_n    = 1'b1;
              err_code_n = ERR_CSUM;
            end
          end else begin
            state_n = state;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    in_ready_n = is_receiving(state_n);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (ADDR_W=8, TIMEOUT=1000).
module tb_imem_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  int checks = 0;
  int fails  = 0;

  int                wcount = 0;
  int                pulse_err = 0;
  logic              prev_wr = 1'b0;
  logic [ADDR_W-1:0] log_addr [0:1023];
  logic [15:0]       log_data [0:1023];

  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Log every RAM write and flag any strobe lasting more than one cycle.
  always @(negedge clk) begin
    prev_wr <= wr_en;
    if (wr_en === 1'b1) begin
      log_addr[wcount] <= wr_addr;
      log_data[wcount] <= wr_data;
      wcount <= wcount + 1;
      if (prev_wr === 1'b1) pulse_err <= pulse_err + 1;
    end
  end

  // All stimulus tasks are entered just after a rising edge.
  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) begin
      checks++;
      fails++;
      $display("FAIL handshake: byte %h not accepted, in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error, err_code} !==
        {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL reset_values: rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b ec=%0d required 0 0 00 0000 1 0 0 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error, err_code);
    end
  endtask

  task automatic test_load_ok();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    send_word(16'h0002);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_word(16'hBE01);
    @(negedge clk);
    checks++;
    if ({done, error, err_code, cpu_reset, in_ready} !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL load_ok_status: dn=%b er=%b ec=%0d cr=%b rdy=%b required 1 0 0 0 0",
               done, error, err_code, cpu_reset, in_ready);
    end
    checks++;
    if (wcount - base !== 2) begin
      fails++;
      $display("FAIL load_ok_wcount: got %0d required 2", wcount - base);
    end
    checks++;
    if ({log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]} !==
        {8'd0, 16'h1234, 8'd1, 16'hABCD}) begin
      fails++;
      $display("FAIL load_ok_writes: got (%h,%h)(%h,%h) required (00,1234)(01,abcd)",
               log_addr[base], log_data[base], log_addr[base+1], log_data[base+1]);
    end
    checks++;
    if (pulse_err !== 0) begin
      fails++;
      $display("FAIL wr_pulse_width: %0d multi-cycle strobes, required 0", pulse_err);
    end
  endtask

  task automatic test_bad_csum();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    @(negedge clk);
    checks++;
    if ({cpu_reset, done, in_ready} !== {1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL restart_from_done: cr=%b dn=%b rdy=%b required 1 0 1", cpu_reset, done, in_ready);
    end
    sync_edge();
    send_word(16'h0002);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_word(16'hBE02);
    @(negedge clk);
    checks++;
    if ({done, error, err_code, cpu_reset} !== {1'b0, 1'b1, 2'd2, 1'b1}) begin
      fails++;
      $display("FAIL bad_csum_status: dn=%b er=%b ec=%0d cr=%b required 0 1 2 1",
               done, error, err_code, cpu_reset);
    end
    checks++;
    if (wcount - base !== 2 || log_data[base] !== 16'h1234 || log_data[base+1] !== 16'hABCD) begin
      fails++;
      $display("FAIL bad_csum_writes: count %0d data %h %h required 2 1234 abcd",
               wcount - base, log_data[base], log_data[base+1]);
    end
  endtask

  task automatic test_bad_len();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    @(negedge clk);
    checks++;
    if ({error, err_code} !== {1'b0, 2'd0}) begin
      fails++;
      $display("FAIL restart_from_error: er=%b ec=%0d required 0 0", error, err_code);
    end
    sync_edge();
    send_word(16'h0000);
    @(negedge clk);
    checks++;
    if ({error, err_code, done, cpu_reset, in_ready} !== {1'b1, 2'd1, 1'b0, 1'b1, 1'b0} || wcount != base) begin
      fails++;
      $display("FAIL len_zero: er=%b ec=%0d dn=%b cr=%b rdy=%b writes=%0d required 1 1 0 1 0 0",
               error, err_code, done, cpu_reset, in_ready, wcount - base);
    end
    sync_edge();
    pulse_start();
    send_word(16'h0101);
    @(negedge clk);
    checks++;
    if ({error, err_code} !== {1'b1, 2'd1} || wcount != base) begin
      fails++;
      $display("FAIL len_257: er=%b ec=%0d writes=%0d required 1 1 0", error, err_code, wcount - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    send_word(16'h0001);
    send_byte(8'h12);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({error, in_ready} !== {1'b0, 1'b1}) begin
      fails++;
      $display("FAIL timeout_early: er=%b rdy=%b after %0d idle cycles required 0 1",
               error, in_ready, TIMEOUT - 1);
    end
    @(posedge clk);
    #1;
    in_byte  = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({error, err_code, cpu_reset, in_ready} !== {1'b1, 2'd3, 1'b1, 1'b0} || wcount != base) begin
      fails++;
      $display("FAIL timeout_expire: er=%b ec=%0d cr=%b rdy=%b writes=%0d required 1 3 1 0 0",
               error, err_code, cpu_reset, in_ready, wcount - base);
    end
  endtask

  task automatic test_stall_ok();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    send_word(16'h0001);
    send_byte(8'h12);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    send_byte(8'h34);
    send_word(16'h1234);
    @(negedge clk);
    checks++;
    if ({done, error, cpu_reset} !== {1'b1, 1'b0, 1'b0} || wcount - base !== 1 ||
        log_data[base] !== 16'h1234) begin
      fails++;
      $display("FAIL stall_resume: dn=%b er=%b cr=%b writes=%0d data=%h required 1 0 0 1 1234",
               done, error, cpu_reset, wcount - base, log_data[base]);
    end
  endtask

  task automatic test_reset_midload();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    send_word(16'h0002);
    send_word(16'h1234);
    apply_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error, err_code} !==
        {1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      fails++;
      $display("FAIL midload_reset: rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b ec=%0d required 0 0 00 0000 1 0 0 0",
               in_ready, wr_en, wr_addr, wr_data, cpu_reset, done, error, err_code);
    end
    checks++;
    if (wcount - base !== 1 || log_data[base] !== 16'h1234) begin
      fails++;
      $display("FAIL midload_first_write: writes=%0d data=%h required 1 1234", wcount - base, log_data[base]);
    end
    sync_edge();
    pulse_start();
    send_word(16'h0002);
    send_word(16'h1234);
    send_word(16'hABCD);
    send_word(16'hBE01);
    @(negedge clk);
    checks++;
    if ({done, cpu_reset, error} !== {1'b1, 1'b0, 1'b0} || wcount - base !== 3) begin
      fails++;
      $display("FAIL reload_after_reset: dn=%b cr=%b er=%b writes=%0d required 1 0 0 3",
               done, cpu_reset, error, wcount - base);
    end
  endtask

  task automatic test_start_ignored();
    int base;
    sync_edge();
    base = wcount;
    pulse_start();
    send_word(16'h0001);
    send_byte(8'hAB);
    pulse_start();
    send_byte(8'hCD);
    send_word(16'hABCD);
    @(negedge clk);
    checks++;
    if ({done, error} !== {1'b1, 1'b0} || wcount - base !== 1 ||
        {log_addr[base], log_data[base]} !== {8'd0, 16'hABCD}) begin
      fails++;
      $display("FAIL start_in_data_lo: dn=%b er=%b writes=%0d (%h,%h) required 1 0 1 (00,abcd)",
               done, error, wcount - base, log_addr[base], log_data[base]);
    end
  endtask

  task automatic test_max_len();
    int base;
    logic [15:0] sum;
    logic [15:0] w;
    sync_edge();
    base = wcount;
    sum = 16'h0000;
    pulse_start();
    send_word(16'h0100);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'(i) ^ 8'h5A};
      sum = sum + w;
      send_word(w);
    end
    send_word(sum);
    @(negedge clk);
    checks++;
    if ({done, error} !== {1'b1, 1'b0} || wcount - base !== 256) begin
      fails++;
      $display("FAIL max_len_status: dn=%b er=%b ec=%0d writes=%0d required 1 0 0 256",
               done, error, err_code, wcount - base);
    end
    checks++;
    if ({log_addr[base+255], log_data[base+255]} !== {8'hFF, 16'hFFA5} || pulse_err !== 0) begin
      fails++;
      $display("FAIL max_len_last_write: (%h,%h) pulse_err=%0d required (ff,ffa5) 0",
               log_addr[base+255], log_data[base+255], pulse_err);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_load_ok();
    test_bad_csum();
    test_bad_len();
    test_timeout();
    test_stall_ok();
    test_reset_midload();
    test_start_ignored();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
